// File: rtl/axil_reg_slave.sv
// axil_reg_slave: parametrised AXI4-Lite slave register bank.
//
// Holds NUM_REGS registers of DATAWIDTH bits each. Registers flagged in
// RO_MASK are read-only and read back their hw_status slice. Registers
// not flagged in RO_MASK are written through byte-strobed AXI4-Lite writes.
// AW and W are accepted independently, in either order.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   aw*/w*/b*             AXI4-Lite write address / data / response channels
//   ar*/r*                AXI4-Lite read address / data channels
//   hw_status             read values for RO registers, register i at [i*DATAWIDTH +: DATAWIDTH]
//   reg_q                 current RW register contents, same packing as hw_status
//   reg_wr                one-cycle pulse per register on a legal write commit
module axil_reg_slave #(
  parameter int unsigned          DATAWIDTH    = 32,
  parameter int unsigned          ADDRWIDTH    = 32,
  parameter int unsigned          NUM_REGS     = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK      = '0,
  parameter bit                   REQUIRE_PRIV = 1'b0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [ADDRWIDTH-1:0]          awaddr,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DATAWIDTH-1:0]          wdata,
  input  logic [DATAWIDTH/8-1:0]        wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [ADDRWIDTH-1:0]          araddr,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [DATAWIDTH-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready,
  input  logic [NUM_REGS*DATAWIDTH-1:0] hw_status,
  output logic [NUM_REGS*DATAWIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]           reg_wr
);

  localparam int unsigned STRBW = DATAWIDTH / 8;
  localparam int unsigned LSB   = $clog2(STRBW);
  localparam int unsigned IDXW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  // Only prot[0] (privileged) matters to this slave.
  logic unused_prot;
  assign unused_prot = ^{awprot[2:1], arprot[2:1]};

  // The full word index is compared, so stray high address bits decode as errors.
  function automatic logic addr_err(input logic [ADDRWIDTH-1:0] a);
    logic [ADDRWIDTH-1:0] word;
    word = a >> LSB;
    return word >= ADDRWIDTH'(NUM_REGS);
  endfunction

  logic                 aw_held_q, aw_held_d;
  logic [ADDRWIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                 aw_priv_q, aw_priv_d;
  logic                 w_held_q,  w_held_d;
  logic [DATAWIDTH-1:0] w_data_q,  w_data_d;
  logic [STRBW-1:0]     w_strb_q,  w_strb_d;
  logic                 bvalid_q,  bvalid_d;
  resp_e                bresp_q,   bresp_d;
  logic                 rvalid_q,  rvalid_d;
  logic [DATAWIDTH-1:0] rdata_q,   rdata_d;
  resp_e                rresp_q,   rresp_d;
  logic [NUM_REGS-1:0]  reg_wr_q,  reg_wr_d;
  logic [DATAWIDTH-1:0] regs_q [NUM_REGS];
  logic [DATAWIDTH-1:0] regs_d [NUM_REGS];
  logic [DATAWIDTH-1:0] hw_arr [NUM_REGS];

  logic            commit;
  logic            wr_err;
  logic            rd_err;
  logic [IDXW-1:0] wr_idx;
  logic [IDXW-1:0] rd_idx;

  assign awready = !aw_held_q;
  assign wready  = !w_held_q;
  assign arready = !rvalid_q || rready;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign reg_wr  = reg_wr_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      hw_arr[i]                           = hw_status[i*DATAWIDTH +: DATAWIDTH];
      reg_q[i*DATAWIDTH +: DATAWIDTH]     = regs_q[i];
    end
  end

  assign wr_idx = aw_addr_q[LSB +: IDXW];
  assign rd_idx = araddr[LSB +: IDXW];
  assign wr_err = addr_err(aw_addr_q) || (REQUIRE_PRIV && !aw_priv_q) || RO_MASK[wr_idx];
  assign rd_err = addr_err(araddr) || (REQUIRE_PRIV && !arprot[0]);

  // A commit only needs room in the B channel: either it is empty or being drained now.
  assign commit = aw_held_q && w_held_q && (!bvalid_q || bready);

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    aw_priv_d = aw_priv_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    reg_wr_d  = '0;
    regs_d    = regs_q;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_err) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d          = RESP_OKAY;
        reg_wr_d[wr_idx] = 1'b1;
        for (int unsigned b = 0; b < STRBW; b++) begin
          if (w_strb_q[b]) regs_d[wr_idx][b*8 +: 8] = w_data_q[b*8 +: 8];
        end
      end
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    if (awvalid && awready) begin
      aw_held_d = 1'b1;
      aw_addr_d = awaddr;
      aw_priv_d = awprot[0];
    end
    if (wvalid && wready) begin
      w_held_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    // Reads sample regs_q, so a same-edge write commit is not yet visible.
    if (arvalid && arready) begin
      rvalid_d = 1'b1;
      if (rd_err) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = RO_MASK[rd_idx] ? hw_arr[rd_idx] : regs_q[rd_idx];
      end
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      aw_priv_q <= 1'b0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      reg_wr_q  <= '0;
      regs_q    <= '{default: '0};
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      aw_priv_q <= aw_priv_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      reg_wr_q  <= reg_wr_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed plus randomized bench for axil_reg_slave.
// A transaction-level model (pending AW/W queues, a register array and
// plain index arithmetic) predicts every output each cycle.
module tb_axil_reg_slave;

  localparam logic [7:0] TB_RO = 8'h09;

  logic          aclk;
  logic          areset;
  logic [31:0]   awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [31:0]   araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [255:0]  hw_status;
  logic [255:0]  reg_q;
  logic [7:0]    reg_wr;

  axil_reg_slave #(
    .DATAWIDTH   (32),
    .ADDRWIDTH   (32),
    .NUM_REGS    (8),
    .RO_MASK     (TB_RO),
    .REQUIRE_PRIV(1'b1)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .awaddr   (awaddr),
    .awprot   (awprot),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arprot   (arprot),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .hw_status(hw_status),
    .reg_q    (reg_q),
    .reg_wr   (reg_wr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] addr; logic p0; } aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;

  logic [31:0] hw [8];
  logic [31:0] m_regs [8];
  aw_t         aw_pend [$];
  w_t          w_pend  [$];
  bit          m_bvalid;
  logic [1:0]  m_bresp;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [7:0]  m_wr;
  bit          model_ok = 0;

  always_comb begin
    for (int i = 0; i < 8; i++) hw_status[i*32 +: 32] = hw[i];
  end

  function automatic logic [255:0] m_packed();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_regs[i];
    return v;
  endfunction

  function automatic void model_read(input logic [31:0] a, input logic [2:0] p,
                                     output logic [31:0] d, output logic [1:0] r);
    longint unsigned word;
    word = a / 4;
    if (word >= 8 || !p[0]) begin
      d = 32'h0; r = 2'b10;
    end else begin
      d = TB_RO[word] ? hw[word] : m_regs[word];
      r = 2'b00;
    end
  endfunction

  always @(posedge aclk) begin
    bit aw_hs, w_hs, ar_hs, do_commit;
    aw_t a;
    w_t  w;
    longint unsigned word;
    if (areset) begin
      model_ok = 1;
      aw_pend.delete();
      w_pend.delete();
      m_bvalid = 0; m_bresp = 2'b00;
      m_rvalid = 0; m_rdata = 32'h0; m_rresp = 2'b00;
      m_wr = 8'h00;
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    end else if (model_ok) begin
      aw_hs     = awvalid && aw_pend.size() == 0;
      w_hs      = wvalid && w_pend.size() == 0;
      ar_hs     = arvalid && (!m_rvalid || rready);
      do_commit = aw_pend.size() > 0 && w_pend.size() > 0 && (!m_bvalid || bready);
      m_wr = 8'h00;
      // read evaluated before this edge's write lands
      if (ar_hs) begin
        model_read(araddr, arprot, m_rdata, m_rresp);
        m_rvalid = 1;
      end else if (m_rvalid && rready) begin
        m_rvalid = 0;
      end
      if (do_commit) begin
        a = aw_pend.pop_front();
        w = w_pend.pop_front();
        word = a.addr / 4;
        if (word >= 8 || !a.p0 || TB_RO[word]) begin
          m_bresp = 2'b10;
        end else begin
          m_bresp = 2'b00;
          m_wr[word] = 1'b1;
          for (int b = 0; b < 4; b++)
            if (w.strb[b]) m_regs[word][8*b +: 8] = w.data[8*b +: 8];
        end
        m_bvalid = 1;
      end else if (m_bvalid && bready) begin
        m_bvalid = 0;
      end
      if (aw_hs) aw_pend.push_back('{addr: awaddr, p0: awprot[0]});
      if (w_hs)  w_pend.push_back('{data: wdata, strb: wstrb});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    if (model_ok) begin
      chk("awready", awready, aw_pend.size() == 0);
      chk("wready",  wready,  w_pend.size() == 0);
      chk("arready", arready, !m_rvalid || rready);
      chk("bvalid",  bvalid,  m_bvalid);
      chk("bresp",   bresp,   m_bresp);
      chk("rvalid",  rvalid,  m_rvalid);
      chk("rdata",   rdata,   m_rdata);
      chk("rresp",   rresp,   m_rresp);
      chk("reg_q",   reg_q,   m_packed());
      chk("reg_wr",  reg_wr,  m_wr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] p, output logic [1:0] resp);
    int n;
    bit aw_done, w_done;
    awaddr = a; awprot = p; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge aclk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge aclk); #2;
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_accept", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid_wait", bvalid, 1'b1);
    resp = bresp;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] p,
                    output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = a; arprot = p; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    @(posedge aclk); #2;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rd_rvalid_wait", rvalid, 1'b1);
    d = rdata; r = rresp;
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 8)       return 32'(k * 4 + $urandom_range(0, 3));
    else if (k == 8) return 32'h20 + 32'($urandom_range(0, 15));
    else             return $urandom;
  endfunction

  function automatic logic [2:0] rand_prot();
    logic [2:0] p;
    p = 3'($urandom);
    if ($urandom_range(0, 3) != 0) p[0] = 1'b1;
    return p;
  endfunction

  // ---------------- main sequence ----------------
  logic [1:0]  resp;
  logic [31:0] rd_d;
  logic [1:0]  rd_r;

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 8; i++) hw[i] = 32'h0;
    tick(); tick();
    areset = 1'b0;
    chk("rst_ready", {awready, wready, arready}, 3'b111);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_regs",  reg_q, 256'h0);

    // single-cycle AW+W, bvalid one edge after acceptance
    awaddr = 32'h08; awprot = 3'b001; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_bvalid_accept_edge", bvalid, 1'b0);
    tick();
    chk("t1_bvalid", bvalid, 1'b1);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_reg_wr", reg_wr, 8'h04);
    chk("t1_reg2", reg_q[64 +: 32], 32'hDEADBEEF);
    tick();
    araddr = 32'h08; arprot = 3'b001; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t1_rvalid", rvalid, 1'b1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_rresp", rresp, 2'b00);
    tick();

    // byte strobes
    wr(32'h04, 32'h11223344, 4'hF, 3'b001, resp);
    wr(32'h04, 32'hAABBCCDD, 4'h5, 3'b001, resp);
    rd(32'h04, 3'b001, rd_d, rd_r);
    chk("t2_strb_rdata", rd_d, 32'h11BB33DD);

    // W ahead of AW, with B back-pressure
    bready = 1'b0;
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    awaddr = 32'h10; awprot = 3'b001; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    chk("t3_bvalid", bvalid, 1'b1);
    chk("t3_reg_wr", reg_wr, 8'h10);
    awaddr = 32'h14; awprot = 3'b001; awvalid = 1'b1;
    wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("t3_held_bvalid", bvalid, 1'b1);
    chk("t3_held_bresp", bresp, 2'b00);
    chk("t3_no_commit", reg_wr, 8'h00);
    bready = 1'b1;
    tick();
    chk("t3_second_commit", reg_wr, 8'h20);
    chk("t3_reg5", reg_q[160 +: 32], 32'h01020304);
    tick();
    chk("t3_bvalid_drained", bvalid, 1'b0);

    // decode error and read-only
    hw[0] = 32'hCAFE0001;
    wr(32'h20, 32'h12345678, 4'hF, 3'b001, resp);
    chk("t4_dec_bresp", resp, 2'b10);
    wr(32'h00, 32'h12345678, 4'hF, 3'b001, resp);
    chk("t4_ro_bresp", resp, 2'b10);
    rd(32'h00, 3'b001, rd_d, rd_r);
    chk("t4_ro_rdata", rd_d, 32'hCAFE0001);
    chk("t4_ro_rresp", rd_r, 2'b00);
    rd(32'h20, 3'b001, rd_d, rd_r);
    chk("t4_dec_rdata", rd_d, 32'h0);
    chk("t4_dec_rresp", rd_r, 2'b10);

    // privilege
    wr(32'h18, 32'h12345678, 4'hF, 3'b000, resp);
    chk("t5_unpriv_bresp", resp, 2'b10);
    chk("t5_unpriv_reg6", reg_q[192 +: 32], 32'h0);
    wr(32'h18, 32'h12345678, 4'hF, 3'b001, resp);
    chk("t5_priv_bresp", resp, 2'b00);
    chk("t5_priv_reg6", reg_q[192 +: 32], 32'h12345678);

    // reset with a held AW and a stalled read beat
    rready = 1'b0;
    awaddr = 32'h1C; awprot = 3'b001; awvalid = 1'b1;
    araddr = 32'h04; arprot = 3'b001; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("t6_ready", {awready, wready, arready}, 3'b111);
    chk("t6_valid", {bvalid, rvalid}, 2'b00);
    chk("t6_regs", reg_q, 256'h0);
    rready = 1'b1;
    wr(32'h1C, 32'h55AA55AA, 4'hF, 3'b001, resp);
    chk("t6_after_bresp", resp, 2'b00);
    chk("t6_after_reg7", reg_q[224 +: 32], 32'h55AA55AA);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      awvalid = ($urandom_range(0, 2) != 0);
      awaddr  = rand_addr();
      awprot  = rand_prot();
      wvalid  = ($urandom_range(0, 2) != 0);
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      bready  = ($urandom_range(0, 3) != 0);
      arvalid = ($urandom_range(0, 1) != 0);
      araddr  = rand_addr();
      arprot  = rand_prot();
      rready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) hw[$urandom_range(0, 7)] = $urandom;
      areset  = ($urandom_range(0, 499) == 0);
      tick();
    end
    areset = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
